// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arb_pkg
//  Purpose : Shared definitions for the data-memory arbiter: default widths,
//            arbiter state encoding and the wait-counter width.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

  localparam int c_AW_DEF   = 32;  // default byte-address width
  localparam int c_DW_DEF   = 32;  // default data width
  localparam int c_XMW_DEF  = 4;   // default X_MAX_WAIT
  localparam int c_WCNT_W   = 4;   // wait counter width, covers X_MAX_WAIT 1..15

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_WAIT  = 2'd1;
  localparam logic [1:0] c_ST_FORCE = 2'd2;
  localparam logic [1:0] c_ST_XRESP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = c_ST_IDLE,
    ST_WAIT  = c_ST_WAIT,
    ST_FORCE = c_ST_FORCE,
    ST_XRESP = c_ST_XRESP
  } arb_state_e;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module  : arb_wait_counter
//  Purpose : Saturating up-counter with synchronous clear. Counts the cycles
//            the X master has lost arbitration; o_hit flags saturation.
//  Ports   : clk, rst     clock / asynchronous active-high reset
//            i_clr        clear to zero (dominates i_inc)
//            i_inc        increment, saturating at i_max
//            i_max        saturation value
//            o_cnt        current count
//            o_hit        o_cnt == i_max
//  Rev     : 1.0  initial release
// ============================================================================
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int W = c_WCNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_cnt,
  output logic         o_hit
);

  logic [W-1:0] r_cnt;
  logic         w_hit;

  assign w_hit = (r_cnt == i_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_hit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_hit = w_hit;

endmodule : arb_wait_counter
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : dmem_arbiter
//  Purpose : Shares the single-port data memory between the core's Memory
//            stage (CPU port, priority) and an external loader/DMA master
//            (X port). X is force-granted for one cycle after losing
//            X_MAX_WAIT cycles in a row, stalling the core for that cycle.
//  Config  : `define DMEM_ARB_PERF_EN adds the stall_cnt output, a 32-bit
//            wrapping count of c_stall cycles.
//  Ports   : clk, reset                      clock / async active-high reset
//            c_req c_we c_addr c_wdata       CPU access in
//            c_rdata c_stall                 CPU read data / stall out
//            x_req x_we x_addr x_wdata       X access in (held until x_ack)
//            x_ack x_rdata                   X registered response
//            mem_we mem_a mem_wd mem_rd      dmem interface
//            stall_cnt                       [DMEM_ARB_PERF_EN] stall count
//  Rev     : 1.0  initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = c_AW_DEF,
  parameter int DW         = c_DW_DEF,
  parameter int X_MAX_WAIT = c_XMW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_ack,
  output logic [DW-1:0] x_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  localparam logic [c_WCNT_W-1:0] c_MAX = c_WCNT_W'(X_MAX_WAIT);

  logic                r_x_ack;
  logic [DW-1:0]       r_x_rdata;
  arb_state_e          r_state;
  arb_state_e          w_state_nxt;

  logic                w_gnt_x;
  logic                w_gnt_c;
  logic                w_force_x;
  logic                w_inc;
  logic                w_clr;
  logic                w_inc_hits;
  logic [c_WCNT_W-1:0] w_wait_cnt;

  // --------------------------------------------------------------------------
  // Grant. The ~r_x_ack term keeps a still-asserted x_req from being served a
  // second time in its acknowledge cycle, which also guarantees the core is
  // never stalled in two consecutive cycles.
  // --------------------------------------------------------------------------
  assign w_gnt_x = x_req & ~r_x_ack & (~c_req | w_force_x);
  assign w_gnt_c = c_req & ~w_gnt_x;

  // X lost this cycle: it is pending, not in its ack cycle, and not granted.
  assign w_inc = x_req & ~r_x_ack & ~w_gnt_x;
  assign w_clr = w_gnt_x | ~x_req;

  arb_wait_counter #(
    .W (c_WCNT_W)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (reset),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .i_max (c_MAX),
    .o_cnt (w_wait_cnt),
    .o_hit (w_force_x)
  );

  // Next loss makes the counter reach the limit, so the following cycle forces.
  assign w_inc_hits = (c_WCNT_W'(w_wait_cnt + 1'b1) == c_MAX);

  // --------------------------------------------------------------------------
  // Memory-side mux. CPU fields are the idle default so that a CPU access
  // always sees the same address path whether or not X is requesting.
  // --------------------------------------------------------------------------
  assign mem_a   = w_gnt_x ? x_addr  : c_addr;
  assign mem_wd  = w_gnt_x ? x_wdata : c_wdata;
  assign mem_we  = (w_gnt_c & c_we) | (w_gnt_x & x_we);

  assign c_rdata = mem_rd;
  assign c_stall = c_req & w_gnt_x;

  // --------------------------------------------------------------------------
  // X response: one-cycle ack pulse; read data captured in the service cycle
  // and held until the next X service.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x_ack   <= 1'b0;
      r_x_rdata <= '0;
    end else begin
      r_x_ack <= w_gnt_x;
      if (w_gnt_x) begin
        r_x_rdata <= mem_rd;
      end
    end
  end

  assign x_ack   = r_x_ack;
  assign x_rdata = r_x_rdata;

  // --------------------------------------------------------------------------
  // Arbitration state, tracking where X is in its wait/force/respond cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_gnt_x) begin
      w_state_nxt = ST_XRESP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_inc) begin
            w_state_nxt = w_inc_hits ? ST_FORCE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!x_req) begin
            w_state_nxt = ST_IDLE;
          end else if (w_inc && w_inc_hits) begin
            w_state_nxt = ST_FORCE;
          end
        end
        ST_FORCE: begin
          if (!x_req) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_XRESP: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // --------------------------------------------------------------------------
  // Stall performance counter, wraps at 2^32.
  // --------------------------------------------------------------------------
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (c_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dmem_arbiter
//  Purpose : Self-checking bench for dmem_arbiter. A behavioural dmem
//            (combinational read, clocked write) closes the loop; a table of
//            per-cycle vectors plus hand-written reset sequences drive it.
//  Config  : DMEM_ARB_PERF_EN enables the stall counter check.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        c_req, c_we, x_req, x_we;
  logic [31:0] c_addr, c_wdata, x_addr, x_wdata;
  logic [31:0] c_rdata, x_rdata, mem_a, mem_wd, mem_rd;
  logic        c_stall, x_ack, mem_we;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.AW(32), .DW(32), .X_MAX_WAIT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .c_req   (c_req),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_wdata (c_wdata),
    .c_rdata (c_rdata),
    .c_stall (c_stall),
    .x_req   (x_req),
    .x_we    (x_we),
    .x_addr  (x_addr),
    .x_wdata (x_wdata),
    .x_ack   (x_ack),
    .x_rdata (x_rdata),
    .mem_we  (mem_we),
    .mem_a   (mem_a),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd)
`ifdef DMEM_ARB_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory, word indexed.
  logic [31:0] mem [0:255];
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[9:2]] <= mem_wd;
  end

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wdata;
    logic        x_req, x_we;
    logic [31:0] x_addr, x_wdata;
    logic        e_we;
    logic [31:0] e_a, e_wd;
    logic        e_stall, e_ack;
    logic [31:0] e_xrd;    // checked only when e_ack
    logic        chk_crd;
    logic [31:0] e_crd;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic xr, input logic xw, input logic [31:0] xa, input logic [31:0] xd,
    input logic ew, input logic [31:0] ea, input logic [31:0] ed,
    input logic es, input logic ek, input logic [31:0] ex,
    input logic cc, input logic [31:0] ec);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.x_req = xr; v.x_we = xw; v.x_addr = xa; v.x_wdata = xd;
    v.e_we = ew; v.e_a = ea; v.e_wd = ed; v.e_stall = es; v.e_ack = ek;
    v.e_xrd = ex; v.chk_crd = cc; v.e_crd = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic xr, input logic xw, input logic [31:0] xa, input logic [31:0] xd);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    x_req = xr; x_we = xw; x_addr = xa; x_wdata = xd;
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    reset = 1'b1;
    drive(0, 0, 32'h80, 32'h55, 0, 0, 32'h0, 32'h0);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x_ack",   {31'b0, x_ack},  32'd0);
    chk("rst_x_rdata", x_rdata,         32'd0);
    chk("rst_mem_we",  {31'b0, mem_we}, 32'd0);
    chk("rst_mem_a",   mem_a,           32'h80);
    chk("rst_mem_wd",  mem_wd,          32'h55);
    reset = 1'b0;

    // ---------------- per-cycle vector table ----------------
    //            c_req we addr      wdata          x_req we addr   wdata        | we addr  wd            stall ack xrd           chk crd
    vecs.push_back(mk(0,0,32'h80,32'h55,        0,0,32'h00,32'h0,          0,32'h80,32'h55,        0,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,1,32'h40,32'hDEADBEEF,  0,0,32'h00,32'h0,          1,32'h40,32'hDEADBEEF,  0,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h40,32'h0,         0,0,32'h00,32'h0,          0,32'h40,32'h0,         0,0,32'h0,        1,32'hDEADBEEF));
    vecs.push_back(mk(0,0,32'h00,32'h0,         1,0,32'h40,32'h0,          0,32'h40,32'h0,         0,0,32'h0,        1,32'hDEADBEEF));
    vecs.push_back(mk(0,0,32'h00,32'h0,         0,0,32'h00,32'h0,          0,32'h00,32'h0,         0,1,32'hDEADBEEF, 0,32'h0));
    vecs.push_back(mk(0,0,32'h00,32'h0,         0,0,32'h00,32'h0,          0,32'h00,32'h0,         0,0,32'h0,        0,32'h0));
    vecs.push_back(mk(0,0,32'h00,32'h0,         1,1,32'h10,32'h12345678,   1,32'h10,32'h12345678,  0,0,32'h0,        0,32'h0));
    vecs.push_back(mk(0,0,32'h00,32'h0,         0,0,32'h00,32'h0,          0,32'h00,32'h0,         0,1,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h10,32'h0,         0,0,32'h00,32'h0,          0,32'h10,32'h0,         0,0,32'h0,        1,32'h12345678));
    // contention: CPU wins 4 cycles, then a forced X read
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,32'h40,32'h0,       1,0,32'h10,32'h0,          0,32'h40,32'h0,         0,0,32'h0,        1,32'hDEADBEEF));
    vecs.push_back(mk(1,0,32'h40,32'h0,         1,0,32'h10,32'h0,          0,32'h10,32'h0,         1,0,32'h0,        1,32'h12345678));
    vecs.push_back(mk(1,0,32'h40,32'h0,         0,0,32'h00,32'h0,          0,32'h40,32'h0,         0,1,32'h12345678, 1,32'hDEADBEEF));
    // one X loss, then x_req drops: the wait count must restart from zero
    vecs.push_back(mk(1,0,32'h40,32'h0,         1,1,32'h30,32'h0BADF00D,   0,32'h40,32'h0,         0,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h40,32'h0,         0,0,32'h00,32'h0,          0,32'h40,32'h0,         0,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,1,32'h20,32'hCAFEF00D,  1,1,32'h30,32'h0BADF00D,   1,32'h20,32'hCAFEF00D,  0,0,32'h0,        0,32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,0,32'h40,32'h0,       1,1,32'h30,32'h0BADF00D,   0,32'h40,32'h0,         0,0,32'h0,        1,32'hDEADBEEF));
    vecs.push_back(mk(1,0,32'h40,32'h0,         1,1,32'h30,32'h0BADF00D,   1,32'h30,32'h0BADF00D,  1,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h30,32'h0,         0,0,32'h00,32'h0,          0,32'h30,32'h0,         0,1,32'h0,        1,32'h0BADF00D));
    vecs.push_back(mk(1,0,32'h20,32'h0,         0,0,32'h00,32'h0,          0,32'h20,32'h0,         0,0,32'h0,        1,32'hCAFEF00D));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.c_req, v.c_we, v.c_addr, v.c_wdata, v.x_req, v.x_we, v.x_addr, v.x_wdata);
      @(negedge clk);
      chk($sformatf("v%0d_mem_we", i),  {31'b0, mem_we},  {31'b0, v.e_we});
      chk($sformatf("v%0d_mem_a", i),   mem_a,            v.e_a);
      chk($sformatf("v%0d_mem_wd", i),  mem_wd,           v.e_wd);
      chk($sformatf("v%0d_c_stall", i), {31'b0, c_stall}, {31'b0, v.e_stall});
      chk($sformatf("v%0d_x_ack", i),   {31'b0, x_ack},   {31'b0, v.e_ack});
      if (v.e_ack)   chk($sformatf("v%0d_x_rdata", i), x_rdata, v.e_xrd);
      if (v.chk_crd) chk($sformatf("v%0d_c_rdata", i), c_rdata, v.e_crd);
      next_cycle();
    end

    // ---------------- reset during an X service cycle ----------------
    // x_rdata currently holds 0 from the last X read of 0x30; load a
    // nonzero value first so the asynchronous clear is visible.
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("pre_rst_x_rdata", x_rdata, 32'h12345678);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
    @(negedge clk);
    chk("svc_mem_a", mem_a, 32'h10);
    reset = 1'b1;
    #1;
    chk("async_x_rdata", x_rdata,        32'h0);
    chk("async_x_ack",   {31'b0, x_ack}, 32'd0);
    next_cycle();
    chk("held_x_ack", {31'b0, x_ack}, 32'd0);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("post_rst_x_ack",  {31'b0, x_ack},  32'd0);
    next_cycle();

    // ---------------- reset clears a partial wait count ----------------
    drive(1, 0, 32'h40, 32'h0, 1, 0, 32'h10, 32'h0);
    repeat (3) next_cycle();           // three losses accumulated
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("rewait%0d_c_stall", i), {31'b0, c_stall}, (i == 5) ? 32'd1 : 32'd0);
      next_cycle();
    end
    drive(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rewait_x_ack",   {31'b0, x_ack},   32'd1);
    chk("rewait_c_stall", {31'b0, c_stall}, 32'd0);
    next_cycle();

`ifdef DMEM_ARB_PERF_EN
    // ---------------- stall counter ----------------
    reset = 1'b1;
    next_cycle();
    chk("perf_rst", stall_cnt, 32'd0);
    reset = 1'b0;
    // x_req held: forced stalls land in cycles 5, 11, 17 and 23
    drive(1, 0, 32'h40, 32'h0, 1, 0, 32'h10, 32'h0);
    repeat (23) next_cycle();
    @(negedge clk);
    chk("perf_stall_cnt", stall_cnt, 32'd4);
    next_cycle();
`endif

    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
